// File: rtl/bs_arbtr_mb.sv
// Multi-bus packet arbiter: per bus, pick one pending driver, pop its head
// packet, then push it to the addressed driver or broadcast it to all others.
// Undeliverable packets (bad or self destination) are counted per bus.
module bs_arbtr_mb #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int          mode      = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [bits*drvrs-1:0]            pndng,
  input  logic [bits*drvrs*pckg_sz-1:0]    D_pop,
  output logic [bits*drvrs-1:0]            pop,
  output logic [bits*drvrs-1:0]            push,
  output logic [bits*pckg_sz-1:0]          D_push,
  output logic [bits-1:0]                  busy,
  output logic [bits*16-1:0]               drop_cnt
);

  localparam int IW = $clog2(drvrs);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  for (genvar gi = 0; gi < bits; gi++) begin : g_bus
    state_t               state_q, state_d;
    logic [drvrs-1:0]     req;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   pkt;
    logic [pckg_sz-1:0]   dpush_q, dpush_d;
    logic [7:0]           dest;
    logic                 busy_q, busy_d;
    logic [15:0]          drop_q, drop_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        win_q, win_d;
    logic [IW-1:0]        sel;
    logic                 found;

    assign req  = pndng[gi*drvrs +: drvrs];
    assign pkt  = D_pop[(gi*drvrs + int'(win_q))*pckg_sz +: pckg_sz];
    assign dest = pkt[pckg_sz-1 -: 8];

    // Winner selection: rotating scan after last grant, or lowest index.
    always_comb begin
      sel   = '0;
      found = 1'b0;
      if (mode == 0) begin
        for (int i = 1; i <= drvrs; i++) begin
          if (!found && req[(int'(last_q) + i) % drvrs]) begin
            found = 1'b1;
            sel   = IW'((int'(last_q) + i) % drvrs);
          end
        end
      end else begin
        for (int i = 0; i < drvrs; i++) begin
          if (!found && req[i]) begin
            found = 1'b1;
            sel   = IW'(i);
          end
        end
      end
    end

    // Next-state and registered-output computation for this bus.
    always_comb begin
      state_d = state_q;
      pop_d   = '0;
      push_d  = '0;
      busy_d  = busy_q;
      dpush_d = dpush_q;
      drop_d  = drop_q;
      last_d  = last_q;
      win_d   = win_q;
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (|req) begin
            win_d      = sel;
            pop_d[sel] = 1'b1;
            busy_d     = 1'b1;
            state_d    = GRANT;
          end
        end
        GRANT: begin
          dpush_d = pkt;
          if (mode == 0) last_d = win_q;
          busy_d  = 1'b1;
          state_d = XFER;
          // Broadcast is checked first so it wins even if it aliases a driver ID.
          if (dest == broadcast) begin
            push_d        = '1;
            push_d[win_q] = 1'b0;
          end else if (int'(dest) < drvrs && int'(dest) != int'(win_q)) begin
            push_d[dest[IW-1:0]] = 1'b1;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
        XFER: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end

    // State and output registers; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        pop_q   <= '0;
        push_q  <= '0;
        dpush_q <= '0;
        busy_q  <= 1'b0;
        drop_q  <= '0;
        last_q  <= IW'(drvrs - 1);
        win_q   <= '0;
      end else begin
        state_q <= state_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
        dpush_q <= dpush_d;
        busy_q  <= busy_d;
        drop_q  <= drop_d;
        last_q  <= last_d;
        win_q   <= win_d;
      end
    end

    assign pop[gi*drvrs +: drvrs]        = pop_q;
    assign push[gi*drvrs +: drvrs]       = push_q;
    assign D_push[gi*pckg_sz +: pckg_sz] = dpush_q;
    assign busy[gi]                      = busy_q;
    assign drop_cnt[gi*16 +: 16]         = drop_q;
  end

endmodule

// File: tb/tb_bs_arbtr_mb.sv
// Bench for bs_arbtr_mb: a round-robin and a fixed-priority instance (two
// buses, four drivers each) share stimulus and are checked against a
// transaction-level model of the arbitration and delivery rules.
module tb_bs_arbtr_mb;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   pnd = '0;
  logic [127:0] dpop = '0;

  logic [7:0]   pop_a, push_a, pop_b, push_b;
  logic [31:0]  dpush_a, dpush_b, drop_a, drop_b;
  logic [1:0]   busy_a, busy_b;

  int total = 0;
  int bad = 0;
  int rnd = 0;

  // Model state, indexed [mode][bus].
  int          mlast[2][2];
  logic [15:0] mdrop[2][2];
  logic [15:0] mdp[2][2];

  bs_arbtr_mb #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .mode(0)) u_rr (
    .clk(clk), .reset(reset), .pndng(pnd), .D_pop(dpop),
    .pop(pop_a), .push(push_a), .D_push(dpush_a), .busy(busy_a), .drop_cnt(drop_a));

  bs_arbtr_mb #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .mode(1)) u_fp (
    .clk(clk), .reset(reset), .pndng(pnd), .D_pop(dpop),
    .pop(pop_b), .push(push_b), .D_push(dpush_b), .busy(busy_b), .drop_cnt(drop_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin: smallest requester above the last grant, else smallest overall.
  // Fixed priority: smallest requester.
  function automatic int pick(input int m, input logic [3:0] mask, input int lst);
    if (m == 0) begin
      for (int d = lst + 1; d < 4; d++) if (mask[d]) return d;
    end
    for (int d = 0; d < 4; d++) if (mask[d]) return d;
    return -1;
  endfunction

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 2; b++) begin
        mlast[m][b] = 3;
        mdrop[m][b] = '0;
        mdp[m][b]   = '0;
      end
    end
  endtask

  task automatic setpkt(input int b, input int d, input logic [15:0] v);
    dpop[(b*4+d)*16 +: 16] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pop_a"},   32'(pop_a),   32'h0);
    chk({tag, "_push_a"},  32'(push_a),  32'h0);
    chk({tag, "_dpush_a"}, dpush_a,      32'h0);
    chk({tag, "_busy_a"},  32'(busy_a),  32'h0);
    chk({tag, "_drop_a"},  drop_a,       32'h0);
    chk({tag, "_pop_b"},   32'(pop_b),   32'h0);
    chk({tag, "_push_b"},  32'(push_b),  32'h0);
    chk({tag, "_busy_b"},  32'(busy_b),  32'h0);
    chk({tag, "_drop_b"},  drop_b,       32'h0);
  endtask

  // One arbitration round: called one step after an edge with both DUTs idle;
  // the current pnd/dpop are held through all three edges.
  task automatic round(input string tag);
    logic [7:0]  epop[2];
    logic [7:0]  epush[2];
    logic [1:0]  ebusy[2];
    logic [3:0]  mask;
    logic [15:0] pkt;
    logic [7:0]  dest;
    logic [3:0]  pm;
    int          w;
    for (int m = 0; m < 2; m++) begin
      epop[m] = '0; epush[m] = '0; ebusy[m] = '0;
      for (int b = 0; b < 2; b++) begin
        mask = pnd[b*4 +: 4];
        if (mask != 4'h0) begin
          w = pick(m, mask, mlast[m][b]);
          pkt  = dpop[(b*4+w)*16 +: 16];
          dest = pkt[15:8];
          epop[m][b*4+w] = 1'b1;
          ebusy[m][b]    = 1'b1;
          if (dest == 8'hFF) pm = 4'hF & ~(4'd1 << w);
          else if (dest < 8'd4 && int'(dest) != w) pm = 4'd1 << dest;
          else begin
            pm = 4'h0;
            if (mdrop[m][b] != 16'hFFFF) mdrop[m][b] = mdrop[m][b] + 16'd1;
          end
          epush[m][b*4 +: 4] = pm;
          mdp[m][b] = pkt;
          if (m == 0) mlast[m][b] = w;
        end
      end
    end
    rnd++;
    $display("round %0d %s pnd=%h rr_pop=%h fp_pop=%h rr_push=%h fp_push=%h",
             rnd, tag, pnd, epop[0], epop[1], epush[0], epush[1]);
    @(posedge clk); #1;
    chk({tag, "_pop_a"},   32'(pop_a),  32'(epop[0]));
    chk({tag, "_pop_b"},   32'(pop_b),  32'(epop[1]));
    chk({tag, "_busy1_a"}, 32'(busy_a), 32'(ebusy[0]));
    chk({tag, "_busy1_b"}, 32'(busy_b), 32'(ebusy[1]));
    chk({tag, "_push0_a"}, 32'(push_a), 32'h0);
    @(posedge clk); #1;
    chk({tag, "_popclr_a"}, 32'(pop_a),  32'h0);
    chk({tag, "_popclr_b"}, 32'(pop_b),  32'h0);
    chk({tag, "_push_a"},   32'(push_a), 32'(epush[0]));
    chk({tag, "_push_b"},   32'(push_b), 32'(epush[1]));
    chk({tag, "_dpush_a"},  dpush_a,     {mdp[0][1], mdp[0][0]});
    chk({tag, "_dpush_b"},  dpush_b,     {mdp[1][1], mdp[1][0]});
    chk({tag, "_drop_a"},   drop_a,      {mdrop[0][1], mdrop[0][0]});
    chk({tag, "_drop_b"},   drop_b,      {mdrop[1][1], mdrop[1][0]});
    chk({tag, "_busy2_a"},  32'(busy_a), 32'(ebusy[0]));
    chk({tag, "_busy2_b"},  32'(busy_b), 32'(ebusy[1]));
    @(posedge clk); #1;
    chk({tag, "_pushclr_a"}, 32'(push_a), 32'h0);
    chk({tag, "_pushclr_b"}, 32'(push_b), 32'h0);
    chk({tag, "_busy3_a"},   32'(busy_a), 32'h0);
    chk({tag, "_busy3_b"},   32'(busy_b), 32'h0);
  endtask

  initial begin
    logic [7:0] dst;
    int         r;
    reset_model();
    // Power-up reset.
    #1 reset = 1'b1;
    #2 chk_all_zero("rst0");
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;

    // Unicast: bus0 driver1 -> driver2.
    setpkt(0, 1, 16'h02AB); pnd = 8'h02;
    round("unicast");
    // Broadcast from driver 2.
    setpkt(0, 2, 16'hFF55); pnd = 8'h04;
    round("bcast");
    // Out-of-range destination, then self-addressed.
    setpkt(0, 0, 16'h0711); pnd = 8'h01;
    round("drop_range");
    setpkt(0, 3, 16'h0312); pnd = 8'h08;
    round("drop_self");
    chk("drop_total", drop_a, 32'h0000_0002);

    // All four requesting: rotation vs fixed priority.
    setpkt(0, 0, 16'h01A0); setpkt(0, 1, 16'h02A1);
    setpkt(0, 2, 16'h03A2); setpkt(0, 3, 16'h00A3);
    pnd = 8'h0F;
    for (int i = 0; i < 5; i++) round("rr");

    // Both buses at once: bus0 driver3 -> 0, bus1 driver0 -> broadcast.
    setpkt(0, 3, 16'h00C3); setpkt(1, 0, 16'hFFC4); pnd = 8'h18;
    round("parallel");

    // Idle bus stays quiet.
    pnd = 8'h00;
    round("idle");

    // Reset asserted mid-GRANT acts without a clock edge.
    setpkt(0, 1, 16'h0201); setpkt(1, 1, 16'h0301); pnd = 8'h22;
    @(posedge clk); #1;
    chk("pre_rst_pop_a", 32'(pop_a), 32'h22);
    chk("pre_rst_pop_b", 32'(pop_b), 32'h22);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_mid");
    #2 reset = 1'b0;
    reset_model();
    setpkt(0, 0, 16'h0102); setpkt(0, 2, 16'h0103); setpkt(0, 3, 16'h0104);
    setpkt(1, 0, 16'h0105); setpkt(1, 2, 16'h0106); setpkt(1, 3, 16'h0107);
    pnd = 8'hFF;
    round("after_rst");

    // Randomized rounds.
    for (int i = 0; i < 40; i++) begin
      pnd = 8'($urandom);
      for (int b = 0; b < 2; b++) begin
        for (int d = 0; d < 4; d++) begin
          r = int'($urandom_range(0, 9));
          if (r <= 5) dst = 8'(r);
          else if (r <= 7) dst = 8'hFF;
          else dst = 8'($urandom);
          setpkt(b, d, {dst, 8'($urandom)});
        end
      end
      round("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bs_arbtr_mb.md
Name: bs_arbtr_mb

Overview:
- Next-generation bus generator/arbiter: `bits` independent buses, each shared by `drvrs` drivers that hold packets in external FIFOs.
- Per bus, it picks one pending driver and pops its head packet. It then pushes that packet to the addressed driver, or to all other drivers on a broadcast.
- Adds a selectable arbitration mode, drop detection for bad destinations, and per-bus busy/drop status.
- Sits between the driver FIFO models and the monitors/checkers in the bus testbench.

Parameters:
- bits, 1, number of independent buses.
- drvrs, 4, drivers per bus (2..255).
- pckg_sz, 16, packet width in bits; minimum 9. Packet[pckg_sz-1 -: 8] is the destination ID; the rest is payload.
- broadcast, 8'hFF, destination ID that means deliver to all drivers except the source.
- mode, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  bits*drvrs  index b*drvrs+d: driver d on bus b has a packet at its FIFO head.
- D_pop  in  bits*drvrs*pckg_sz  head packet of each driver FIFO; slice (b*drvrs+d)*pckg_sz; valid while the matching pndng is high.
- pop  out  bits*drvrs  one-cycle pulse: consume the head of that FIFO.
- push  out  bits*drvrs  one-cycle pulse: driver d on bus b accepts the D_push of bus b.
- D_push  out  bits*pckg_sz  per-bus data; held until the next capture.
- busy  out  bits  bus b is in GRANT or XFER.
- drop_cnt  out  bits*16  per-bus count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered. One FSM per bus; buses never interact.
- Reset (asynchronous, any time, including mid-transfer):
  - pop, push, D_push, busy and drop_cnt all go to 0.
  - Every FSM goes to IDLE.
  - The round-robin pointer last[b] goes to drvrs-1, so driver 0 wins first.
- States: IDLE -> GRANT -> XFER -> IDLE.
- IDLE, at an edge where pndng[b] != 0:
  - Select the winner w.
  - mode 0: first set bit scanning from last[b]+1 upward, wrapping modulo drvrs.
  - mode 1: lowest set index.
  - Latch w, set pop[b][w]=1 and busy[b]=1, go to GRANT.
  - With no pndng, stay in IDLE with all outputs quiet.
- GRANT (exactly one cycle):
  - Capture D_push[b] <= D_pop[b][w]. Clear pop. Set last[b] <= w (mode 0 only). Go to XFER.
  - Decode dest = D_pop[b][w][pckg_sz-1 -: 8]:
    - dest == broadcast: push all drivers on bus b except w.
    - dest < drvrs and dest != w: push only dest.
    - Otherwise (out of range, or self-addressed): push nothing and increment drop_cnt[b] (saturating).
- XFER (one cycle): clear push and busy, go to IDLE.
- Latency and throughput:
  - pndng seen at edge k -> pop high in cycle k..k+1 -> push high in cycle k+1..k+2.
  - One packet per bus every 3 cycles at most.
- pndng is sampled only in IDLE. The environment must hold the winner's pndng and D_pop stable through GRANT; the block does not check this.
- pndng changes during GRANT/XFER take effect at the next IDLE arbitration.
- Simultaneous requests on different buses are served in parallel, with identical timing.
- If broadcast < drvrs, the broadcast meaning takes precedence over unicast.

Test Plan:
- Reset check: assert reset mid-GRANT (pop high) -> pop, push, busy, D_push and drop_cnt go to 0 immediately, without waiting for clk; after release, the first grant goes to driver 0.
- Unicast, defaults: driver 1 pndng with D_pop=16'h02AB -> pop[1] one cycle, then D_push=16'h02AB with push=4'b0100 one cycle; busy high for 2 cycles.
- Broadcast: driver 2 sends 16'hFF55 -> push=4'b1011; drop_cnt stays 0.
- Drops: driver 0 sends 16'h0711 (dest 7 >= 4), then driver 3 sends 16'h0312 (self-addressed) -> push stays 0 for both; drop_cnt=2; each pop still issued.
- Round-robin: all 4 pndng held high, mode 0 -> grant order 0,1,2,3,0, one grant every 3 cycles. With mode=1, every grant goes to 0.
- Parallel buses (bits=2): simultaneous requests on bus 0 (driver 3 -> dest 0) and bus 1 (driver 0 -> broadcast) -> both pop on the same cycle; push bus0=4'b0001 and bus1=4'b1110 on the same cycle.
